// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with manual-select and auto-scan modes.
// Auto-scan holds each channel for dwell+1 cycles and pulses wrap on the NCH-1 -> 0 step.
module mux_scan_n #(
  parameter int WIDTH   = 8,
  parameter int NCH     = 4,
  parameter int SELW    = 2,
  parameter int DWELL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*WIDTH-1:0]   din,
  input  logic                   en,
  input  logic                   mode,
  input  logic [SELW-1:0]        sel,
  input  logic [DWELL_W-1:0]     dwell,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic [SELW-1:0]        cur_ch,
  output logic                   wrap
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic [SELW:0]   NCH_L   = (SELW+1)'(NCH);
  localparam logic [SELW-1:0] LAST_CH = SELW'(NCH - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     dout_q, dout_d;
  logic                 valid_q, valid_d;
  logic [SELW-1:0]      ch_q, ch_d;
  logic                 wrap_q, wrap_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;

  // Indices at or above NCH select nothing, so a non-power-of-two NCH never aliases.
  function automatic logic [WIDTH-1:0] pick_ch(input logic [NCH*WIDTH-1:0] data,
                                               input logic [SELW-1:0]      idx);
    logic [WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < NCH; k++) begin
      res = (idx == SELW'(k)) ? data[k*WIDTH +: WIDTH] : res;
    end
    return res;
  endfunction

  function automatic logic ch_legal(input logic [SELW-1:0] idx);
    return ({1'b0, idx} < NCH_L);
  endfunction

  // Next-state and datapath decode; the mode taken at an edge follows en/mode directly.
  always_comb begin
    state_d = ST_IDLE;
    dout_d  = dout_q;
    valid_d = 1'b0;
    ch_d    = ch_q;
    wrap_d  = 1'b0;
    cnt_d   = '0;

    if (!en) begin
      state_d = ST_IDLE;
    end else if (!mode) begin
      state_d = ST_MANUAL;
    end else begin
      state_d = ST_SCAN;
    end

    case (state_d)
      ST_IDLE: begin
        dout_d  = dout_q;
        valid_d = 1'b0;
      end
      ST_MANUAL: begin
        if (ch_legal(sel)) begin
          dout_d  = pick_ch(din, sel);
          ch_d    = sel;
          valid_d = 1'b1;
        end else begin
          dout_d  = '0;
          ch_d    = ch_q;
          valid_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (state_q != ST_SCAN) begin
          // Entry edge: stay on the current channel and start a fresh dwell.
          ch_d  = ch_legal(ch_q) ? ch_q : '0;
          cnt_d = '0;
        end else if (cnt_q >= dwell) begin
          cnt_d = '0;
          if (ch_q >= LAST_CH) begin
            ch_d   = '0;
            wrap_d = (ch_q == LAST_CH);
          end else begin
            ch_d   = ch_q + SELW'(1);
            wrap_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
          ch_d  = ch_q;
        end
        dout_d  = pick_ch(din, ch_d);
        valid_d = 1'b1;
      end
      default: begin
        dout_d  = dout_q;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign cur_ch     = ch_q;
  assign wrap       = wrap_q;

endmodule
